// File: rtl/lsu_dm.sv
// rtl/lsu_dm.sv - load/store unit driving a req/ack data memory port
//
// Purpose: takes the ALU result as a byte address and RT as store data, runs one
// request/acknowledge transaction on the data memory port, and returns an aligned,
// extended load result. The PC is stalled while an operation is in flight.
//
// Ports:
//   clk, reset          core clock (rising edge), asynchronous active-low reset
//   req_*               load/store request from the core, held while stall=1
//   stall               combinational PC / register-file freeze
//   load_data/_valid    registered load result and its one-cycle update strobe
//   addr_err, bus_err   one-cycle error pulses (misaligned/illegal, timeout)
//   mem_*               data memory request/acknowledge port
module lsu_dm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  // Last BUSY cycle index before the transaction is declared lost.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Request decode: alignment check, byte enables and lane replication.
  always_comb begin
    req_bad  = 1'b0;
    req_be   = 4'b1111;
    req_wrep = req_wdata;
    case (req_size)
      2'b00: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad  = req_addr[0];
        req_be   = 4'b0011 << {req_addr[1], 1'b0};
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_bad  = |req_addr[1:0];
      end
      default: begin
        req_bad  = 1'b1;
      end
    endcase
  end

  // Load lane extraction uses the address bits latched at accept time.
  always_comb begin
    rd_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            addr_err_d = 1'b1;
            state_d    = ERR;
          end else begin
            size_d      = req_size;
            uns_d       = req_unsigned;
            lo_d        = req_addr[1:0];
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[31:2];
            mem_be_d    = req_be;
            mem_wdata_d = req_wrep;
            mem_req_d   = 1'b1;
            cnt_d       = 8'd0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is tested first so an ack in the final allowed cycle still completes.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) begin
            load_data_d  = rd_ext;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == LAST_CNT) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ERR;
        end
      end
      // req_valid seen here still belongs to the instruction just finished.
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 30'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dm.sv
// tb/tb_lsu_dm.sv - self-checking bench for lsu_dm
module tb_lsu_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, addr_err, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int cur   = -1;

  lsu_dm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .addr_err(addr_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = completes, 1 = address error, 2 = bus timeout
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          kind;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] ld;
    int          hi;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %h want %h", cur, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int hi;
    @(negedge clk);
    chk("idle_req", mem_req, 0);
    chk("idle_lv", load_valid, 0);
    chk("idle_aerr", addr_err, 0);
    chk("idle_berr", bus_err, 0);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    #1 chk("stall_idle", stall, 1);
    @(negedge clk);
    if (v.kind == 1) begin
      chk("addr_err", addr_err, 1);
      chk("aerr_req", mem_req, 0);
      chk("aerr_stall", stall, 0);
      chk("aerr_ld", load_data, v.ld);
      req_valid = 1'b0;
      return;
    end
    hi = 0;
    for (int k = 0; k < 40 && mem_req === 1'b1; k++) begin
      hi++;
      chk("busy_stall", stall, 1);
      chk("busy_we", mem_we, v.we);
      chk("busy_addr", mem_addr, v.addr[31:2]);
      chk("busy_be", mem_be, v.be);
      if (v.we) chk("busy_wdata", mem_wdata, v.mwdata);
      if (k == v.delay) begin
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
    end
    chk("req_cycles", hi, v.hi);
    chk("end_stall", stall, 0);
    chk("end_aerr", addr_err, 0);
    chk("end_ld", load_data, v.ld);
    if (v.kind == 2) begin
      chk("bus_err", bus_err, 1);
      chk("berr_lv", load_valid, 0);
    end else begin
      chk("no_berr", bus_err, 0);
      chk("load_valid", load_valid, !v.we);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0,  0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h8011_2233, 0,  0, 4'h8, 32'h0, 32'hFFFF_FF80, 1};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 32'h8011_2233, 0,  0, 4'h8, 32'h0, 32'h0000_0080, 1};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 3,  0, 4'hC, 32'hABCD_ABCD, 32'h0000_0080, 4};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0,  1, 4'h0, 32'h0, 32'h0000_0080, 0};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0,  1, 4'h0, 32'h0, 32'h0000_0080, 0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h5555_5555, 99, 2, 4'hF, 32'h0, 32'h0000_0080, 16};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1122_3344, 15, 0, 4'hF, 32'h0, 32'h1122_3344, 16};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 0,  0, 4'hC, 32'h0, 32'hFFFF_8001, 1};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 0, 0, 4'h2, 32'hA5A5_A5A5, 32'hFFFF_8001, 1};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0,  1, 4'h0, 32'h0, 32'hFFFF_8001, 0};
    vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_F00D, 2,  0, 4'h3, 32'h0, 32'h0000_F00D, 3};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0,  0, 4'h2, 32'h0, 32'h0000_007F, 1};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'hFFFF_FFF8, 32'hCAFE_F00D, 32'h0, 1, 0, 4'hF, 32'hCAFE_F00D, 32'h0000_007F, 2};

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_aerr", addr_err, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;

    // Reset in the middle of BUSY drops mem_req without waiting for a clock edge.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0040; req_wdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("mid_req_up", mem_req, 1);
    #2 reset = 1'b0;
    #1 chk("async_req_drop", mem_req, 0);
    req_valid = 1'b0;
    #1 chk("async_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_be", mem_be, 0);
    chk("post_rst_wdata", mem_wdata, 0);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_berr", bus_err, 0);
    chk("post_rst_lv", load_valid, 0);

    for (int i = 0; i < 14; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end
    cur = 99;

    // An ack with no transaction in flight must be ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_lv", load_valid, 0);
    @(negedge clk);
    chk("stray_ack_ld", load_data, 32'h0000_007F);
    chk("stray_ack_lv2", load_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_dm.md
Name: lsu_dm

Overview:
- Load/store unit sitting directly downstream of the core's ALU.
- Consumes the ALU result as effective address and the RT read value as store data.
- Runs a multi-cycle request/acknowledge transaction to an external data memory.
- Returns aligned, sign- or zero-extended load data to the register-file write-data select.
- Stalls the PC while a memory operation is in flight.

Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for mem_ack before a bus error; range 2..255.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  core presents a load/store this cycle; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address (ALU output).
- req_wdata  in  32  store data; low byte/half/word used according to size.
- stall  out  1  freeze PC/register-file write.
- load_data  out  32  extended load result, registered.
- load_valid  out  1  one-cycle pulse when load_data updates.
- addr_err  out  1  one-cycle pulse on misaligned or illegal-size request.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  30  word address = req_addr[31:2].
- mem_be  out  4  byte enables; bit k covers mem_wdata[8k+7:8k].
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completes; mem_rdata valid in the same cycle for loads.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - All registered outputs clear to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, load_valid, addr_err, bus_err.
  - Timeout counter clears to 0.
  - Reset mid-transaction drops mem_req immediately; the transaction is abandoned and no pulse is produced.
- FSM states: IDLE, BUSY, DONE, ERR.
- stall is combinational: stall = (IDLE & req_valid) | BUSY. It is 0 in DONE and ERR, so the core advances at the end of that cycle.
- Alignment check (in IDLE, when req_valid=1):
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
  - Illegal: size=11.
  - Either case → ERR; nothing is latched and mem_req is never raised.
- IDLE accept (req_valid=1, request aligned):
  - Latch we, size, unsigned, addr[1:0], mem_addr, mem_be, mem_wdata.
  - Set mem_req=1; clear the counter; → BUSY.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- BUSY:
  - mem_* outputs are held constant; the counter increments each cycle.
  - On mem_ack: drop mem_req at the next edge → DONE.
  - For a load, also capture mem_rdata into load_data:
    - Extract the lane selected by the latched addr[1:0] (little-endian).
    - Extend to 32 bits per req_unsigned: zero-fill if 1, replicate the MSB if 0.
    - Word loads ignore req_unsigned.
  - If the counter reaches TIMEOUT-1 with no ack: drop mem_req → ERR; load_data is unchanged.
  - mem_ack and the timeout in the same cycle: ack wins.
- DONE:
  - load_valid=1 for this cycle if the op was a load; 0 for stores.
  - → IDLE unconditionally. req_valid seen in DONE belongs to the completed instruction and is ignored.
- ERR:
  - addr_err=1 or bus_err=1 (whichever caused the entry) for this one cycle.
  - → IDLE unconditionally.
- Signals outside their states:
  - mem_ack in IDLE, DONE or ERR is ignored.
  - load_data holds its value until the next load DONE.
- Latency:
  - Minimum is ack in the first BUSY cycle: 3 cycles total (IDLE stall, BUSY stall, DONE).
  - Each ack delay cycle adds 1.
  - Back-to-back requests are accepted from the cycle after DONE.
- Width rules: mem_addr drops addr[1:0]; there is no address wrap logic.

Test Plan:
- Reset low with mem_req high in BUSY → mem_req=0 asynchronously; state IDLE; all outputs 0 after release.
- Word load at addr 0x0000_0104, ack in first BUSY cycle with rdata 0xDEADBEEF → mem_addr=0x41, mem_be=1111; stall high 2 cycles; DONE cycle load_valid=1, load_data=0xDEADBEEF.
- Signed byte load at addr 0x...03, rdata 0x80112233 → mem_be=1000, load_data=0xFFFFFF80. Same with req_unsigned=1 → 0x00000080.
- Halfword store at addr 0x...02, wdata 0x1234ABCD, ack after 3 wait cycles → mem_be=1100, mem_wdata=0xABCDABCD held stable across 4 BUSY cycles; no load_valid; stall drops in DONE.
- Word load at addr 0x...01 → addr_err pulse one cycle after request, mem_req never rises. size=11 at an aligned address → same response.
- Load with no ack (TIMEOUT=16) → mem_req high exactly 16 cycles, then bus_err pulse; load_data unchanged. Ack arriving in the 16th cycle → normal DONE, no bus_err.
